// File: rtl/hilo_muldiv_ctrl_if.sv
// hilo_muldiv_ctrl_if: execute-stage request and HI/LO result bundle for hilo_muldiv_ctrl
// master: execute stage (drives start/op/operands/rd_req/flush, observes results)
// slave : hilo_muldiv_ctrl (observes requests, drives hi/lo/busy/done/stall)
interface hilo_muldiv_ctrl_if;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] srca_i;
  logic [31:0] srcb_i;
  logic        rd_req_i;
  logic        flush_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        done_o;
  logic        stall_o;
  modport master (output start_i, op_i, srca_i, srcb_i, rd_req_i, flush_i,
                  input hi_o, lo_o, busy_o, done_o, stall_o);
  modport slave (input start_i, op_i, srca_i, srcb_i, rd_req_i, flush_i,
                 output hi_o, lo_o, busy_o, done_o, stall_o);
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: MIPS HI/LO register pair with iterative multiply/divide and MTHI/MTLO
// Ports: clk (rising-edge clock), resetn (async active-low reset),
//   bus (slave modport): start_i/op_i/srca_i/srcb_i/rd_req_i/flush_i in,
//   hi_o/lo_o committed HI/LO, busy_o, done_o pulse, stall_o out.
// Op codes: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
// Macro HILO_FAST_MULT_EN: single-cycle registered multiplier instead of shift-add.
module hilo_muldiv_ctrl (
  input logic clk,
  input logic resetn,
  hilo_muldiv_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`ifdef HILO_FAST_MULT_EN
  localparam bit FAST_MULT = 1'b1;
`else
  localparam bit FAST_MULT = 1'b0;
`endif
  state_t r_state, w_next;
  logic [31:0] r_hi, r_lo, r_b;
  logic [63:0] r_p;
  logic [5:0]  r_cnt;
  logic        r_mul, r_dz, r_neg_q, r_neg_r;
  logic        w_accept, w_muldiv, w_signed, w_dz, w_write;
  logic [31:0] w_a_mag, w_b_mag, w_quo, w_rmd;
  logic [32:0] w_msum;
  logic [33:0] w_diff;
  logic [63:0] w_mstep, w_dstep, w_mres, w_raw, w_prod;
  assign w_accept = r_state != BUSY && bus.start_i && bus.op_i <= 3'd5 && !bus.flush_i;
  assign w_muldiv = !bus.op_i[2];
  assign w_signed = !bus.op_i[0];
  assign w_dz     = bus.op_i[1] && bus.srcb_i == 32'd0;
  assign w_a_mag  = (w_signed && bus.srca_i[31]) ? -bus.srca_i : bus.srca_i;
  assign w_b_mag  = (w_signed && bus.srcb_i[31]) ? -bus.srcb_i : bus.srcb_i;
  // Shift-add step: r_p holds {partial product, remaining multiplier bits}.
  assign w_msum  = {1'b0, r_p[63:32]} + {1'b0, r_b};
  assign w_mstep = r_p[0] ? {w_msum, r_p[31:1]} : {1'b0, r_p[63:1]};
  // Restoring step: 33-bit shifted remainder so a divisor above 2^31 cannot overflow.
  assign w_diff  = {1'b0, r_p[63:31]} - {2'b00, r_b};
  assign w_dstep = w_diff[33] ? {r_p[62:0], 1'b0} : {w_diff[31:0], r_p[30:0], 1'b1};
`ifdef HILO_FAST_MULT_EN
  assign w_mres = {32'd0, r_p[31:0]} * {32'd0, r_b};
`else
  assign w_mres = w_mstep;
`endif
  assign w_raw   = r_mul ? w_mres : w_dstep;
  assign w_prod  = r_neg_q ? -w_raw : w_raw;
  assign w_quo   = r_neg_q ? -w_raw[31:0] : w_raw[31:0];
  assign w_rmd   = r_neg_r ? -w_raw[63:32] : w_raw[63:32];
  assign w_write = r_state == BUSY && r_cnt == 6'd0 && !bus.flush_i && !r_dz;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == BUSY) w_next = bus.flush_i ? IDLE : (r_cnt == 6'd0 ? DONE : BUSY);
    else w_next = (w_accept && w_muldiv) ? BUSY : IDLE;
    bus.busy_o  = r_state == BUSY;
    bus.done_o  = r_state == DONE;
    bus.stall_o = r_state == BUSY && (bus.start_i || bus.rd_req_i);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_p     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_mul   <= 1'b0;
      r_dz    <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      if (w_accept && w_muldiv) begin
        r_p     <= {32'd0, w_a_mag};
        r_b     <= w_b_mag;
        r_mul   <= !bus.op_i[1];
        r_dz    <= w_dz;
        // Divide-by-zero and the fast multiplier finish after a single BUSY cycle.
        r_cnt   <= (w_dz || (FAST_MULT && !bus.op_i[1])) ? 6'd0 : 6'd31;
        r_neg_q <= w_signed && (bus.srca_i[31] ^ bus.srcb_i[31]);
        r_neg_r <= w_signed && bus.srca_i[31];
      end else if (r_state == BUSY) begin
        r_p   <= w_raw;
        r_cnt <= r_cnt == 6'd0 ? 6'd0 : r_cnt - 6'd1;
      end
      if (w_accept && bus.op_i == 3'd4) r_hi <= bus.srca_i;
      if (w_accept && bus.op_i == 3'd5) r_lo <= bus.srca_i;
      if (w_write) begin
        r_hi <= r_mul ? w_prod[63:32] : w_rmd;
        r_lo <= r_mul ? w_prod[31:0] : w_quo;
      end
    end
  end
  assign bus.hi_o = r_hi;
  assign bus.lo_o = r_lo;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: directed self-checking bench for hilo_muldiv_ctrl
module tb_hilo_muldiv_ctrl;
`ifdef HILO_FAST_MULT_EN
  localparam int MB = 1;
`else
  localparam int MB = 32;
`endif
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int errors = 0;
  int checks = 0;
  int n;
  hilo_muldiv_ctrl_if bus();
  hilo_muldiv_ctrl dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_i = 1'b1;
    bus.op_i = op;
    bus.srca_i = a;
    bus.srcb_i = b;
    tick;
    bus.start_i = 1'b0;
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.busy_o === 1'b1 && cyc < 100) begin
      cyc++;
      tick;
    end
  endtask
  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int exp_busy,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(op, a, b);
    wait_done(n);
    chk({tag, "_busy_len"}, n, exp_busy);
    chk({tag, "_done"}, {31'd0, bus.done_o}, 32'd1);
    chk({tag, "_hi"}, bus.hi_o, exp_hi);
    chk({tag, "_lo"}, bus.lo_o, exp_lo);
    tick;
    chk({tag, "_done_pulse"}, {31'd0, bus.done_o}, 32'd0);
  endtask
  initial begin
    bus.start_i = 1'b1;
    bus.op_i = 3'd4;
    bus.srca_i = 32'hDEADBEEF;
    bus.srcb_i = 32'd0;
    bus.rd_req_i = 1'b1;
    bus.flush_i = 1'b0;
    tick;
    chk("rst_hi", bus.hi_o, 32'd0);
    chk("rst_lo", bus.lo_o, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rst_done", {31'd0, bus.done_o}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_o}, 32'd0);
    bus.start_i = 1'b0;
    bus.rd_req_i = 1'b0;
    resetn = 1'b1;
    tick;
    run("mult", 3'd0, 32'hFFFFFFFE, 32'h3, MB, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, MB, 32'hFFFFFFFE, 32'h1);
    run("mult_nn", 3'd0, 32'hFFFFFFFD, 32'hFFFFFFFC, MB, 32'h0, 32'hC);
    run("div_neg", 3'd2, 32'hFFFFFFF9, 32'h2, 32, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("div_negb", 3'd2, 32'h7, 32'hFFFFFFFE, 32, 32'h1, 32'hFFFFFFFD);
    run("divu_big", 3'd3, 32'hFFFFFFFF, 32'h80000001, 32, 32'h7FFFFFFE, 32'h1);
    issue(3'd4, 32'h5, 32'h0);
    chk("mthi", bus.hi_o, 32'h5);
    issue(3'd5, 32'h5, 32'h0);
    chk("mtlo", bus.lo_o, 32'h5);
    run("divu_zero", 3'd3, 32'd100, 32'd0, 1, 32'h5, 32'h5);
    bus.flush_i = 1'b1;
    issue(3'd5, 32'hAAAA5555, 32'h0);
    bus.flush_i = 1'b0;
    chk("flush_prio_lo", bus.lo_o, 32'h5);
    chk("flush_prio_busy", {31'd0, bus.busy_o}, 32'd0);
    issue(3'd3, 32'd100, 32'd7);
    bus.rd_req_i = 1'b1;
    #1;
    chk("rdreq_stall", {31'd0, bus.stall_o}, 32'd1);
    bus.rd_req_i = 1'b0;
    #1;
    chk("nostall", {31'd0, bus.stall_o}, 32'd0);
    tick;
    bus.start_i = 1'b1;
    bus.op_i = 3'd6;
    #1;
    chk("invalid_stall", {31'd0, bus.stall_o}, 32'd1);
    bus.start_i = 1'b0;
    repeat (8) tick;
    chk("busy_c10", {31'd0, bus.busy_o}, 32'd1);
    bus.flush_i = 1'b1;
    tick;
    bus.flush_i = 1'b0;
    chk("flush10_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("flush10_done", {31'd0, bus.done_o}, 32'd0);
    chk("flush10_hi", bus.hi_o, 32'h5);
    chk("flush10_lo", bus.lo_o, 32'h5);
    tick;
    chk("flush10_done2", {31'd0, bus.done_o}, 32'd0);
    issue(3'd2, 32'd100, 32'd7);
    repeat (31) tick;
    chk("busy_c32", {31'd0, bus.busy_o}, 32'd1);
    bus.flush_i = 1'b1;
    tick;
    bus.flush_i = 1'b0;
    chk("flush32_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("flush32_done", {31'd0, bus.done_o}, 32'd0);
    chk("flush32_hi", bus.hi_o, 32'h5);
    chk("flush32_lo", bus.lo_o, 32'h5);
    tick;
    issue(3'd3, 32'd100, 32'd7);
    bus.start_i = 1'b1;
    bus.op_i = 3'd4;
    bus.srca_i = 32'h12345678;
    #1;
    chk("mthi_busy_stall", {31'd0, bus.stall_o}, 32'd1);
    chk("mthi_busy_hi", bus.hi_o, 32'h5);
    wait_done(n);
    chk("mthi_q_len", n, 32);
    chk("mthi_q_done", {31'd0, bus.done_o}, 32'd1);
    chk("divu_hi", bus.hi_o, 32'd2);
    chk("divu_lo", bus.lo_o, 32'd14);
    tick;
    bus.start_i = 1'b0;
    chk("mthi_done_hi", bus.hi_o, 32'h12345678);
    chk("mthi_done_lo", bus.lo_o, 32'd14);
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) tick;
    resetn = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, bus.busy_o}, 32'd0);
    chk("rstmid_hi", bus.hi_o, 32'd0);
    chk("rstmid_lo", bus.lo_o, 32'd0);
    tick;
    resetn = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) n++;
    end
    chk("rstmid_quiet", n, 32'd0);
    chk("rstmid_hi2", bus.hi_o, 32'd0);
    chk("rstmid_lo2", bus.lo_o, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
